// File: rtl/spi_cfg_controller.sv
// Mode-0 SPI controller: one 16-bit register-access frame per accepted request,
// MSB first, with CIPO captured into rd_data at frame completion.
module spi_cfg_controller #(
    parameter int CLK_DIV = 4,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              sclk,
    output logic              ncs,
    output logic              copi,
    input  logic              cipo
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(CLK_DIV + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEAD = 3'd1,
        S_HIGH = 3'd2,
        S_LOW  = 3'd3,
        S_GAP  = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [FRAME_W-1:0]   tx_q, tx_d;
    logic [FRAME_W-1:0]   rx_q, rx_d;
    logic [DATA_W-1:0]    rd_data_q, rd_data_d;
    logic                 sclk_q, sclk_d;
    logic                 ncs_q, ncs_d;
    logic                 copi_q, copi_d;
    logic                 done_q, done_d;
    logic                 ready_q, ready_d;
    logic                 cnt_last_s;
    logic [FRAME_W-1:0]   frame_s;

    assign cnt_last_s = (cnt_q == CNT_W'(CLK_DIV - 1));
    // Reads carry an all-zero data field regardless of req_wdata.
    assign frame_s    = {req_write, req_addr, (req_write ? req_wdata : {DATA_W{1'b0}})};

    // Next-state and registered-output computation for the frame sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rd_data_d = rd_data_q;
        sclk_d    = sclk_q;
        ncs_d     = ncs_q;
        copi_d    = copi_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid && ready_q) begin
                    state_d = S_LEAD;
                    ncs_d   = 1'b0;
                    copi_d  = frame_s[FRAME_W-1];
                    tx_d    = {frame_s[FRAME_W-2:0], 1'b0};
                    rx_d    = {FRAME_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    bit_d   = 4'd0;
                end else begin
                    cnt_d = {CNT_W{1'b0}};
                end
            end
            S_LEAD: begin
                if (cnt_last_s) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = S_HIGH;
                    sclk_d  = 1'b1;
                    rx_d    = {rx_q[FRAME_W-2:0], cipo};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (cnt_last_s) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = S_LOW;
                    sclk_d  = 1'b0;
                    copi_d  = tx_q[FRAME_W-1];
                    tx_d    = {tx_q[FRAME_W-2:0], 1'b0};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LOW: begin
                if (cnt_last_s) begin
                    cnt_d = {CNT_W{1'b0}};
                    if (bit_q == 4'(FRAME_W - 1)) begin
                        state_d = S_GAP;
                        ncs_d   = 1'b1;
                        copi_d  = 1'b0;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        state_d = S_HIGH;
                        sclk_d  = 1'b1;
                        rx_d    = {rx_q[FRAME_W-2:0], cipo};
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_last_s) begin
                    cnt_d     = {CNT_W{1'b0}};
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    rd_data_d = rx_q[DATA_W-1:0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CNT_W{1'b0}};
                sclk_d  = 1'b0;
                ncs_d   = 1'b1;
                copi_d  = 1'b0;
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    // State and output registers; reset abandons any partial frame silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            bit_q     <= 4'd0;
            tx_q      <= {FRAME_W{1'b0}};
            rx_q      <= {FRAME_W{1'b0}};
            rd_data_q <= {DATA_W{1'b0}};
            sclk_q    <= 1'b0;
            ncs_q     <= 1'b1;
            copi_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rd_data_q <= rd_data_d;
            sclk_q    <= sclk_d;
            ncs_q     <= ncs_d;
            copi_q    <= copi_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    assign req_ready = ready_q;
    assign busy      = ~ready_q;
    assign done      = done_q;
    assign rd_data   = rd_data_q;
    assign sclk      = sclk_q;
    assign ncs       = ncs_q;
    assign copi      = copi_q;

endmodule

// File: tb/tb_spi_cfg_controller.sv
// Bench for spi_cfg_controller: cycle-offset model of the frame, peripheral
// stand-in on CIPO, and literal frame/timing checks per scenario.
module tb_spi_cfg_controller;

    localparam int D = 2;

    logic       clk, rst;
    logic       req_valid, req_ready, req_write, done, busy, sclk, ncs, copi, cipo;
    logic [6:0] req_addr;
    logic [7:0] req_wdata, rd_data;

    logic       req_valid4, req_ready4, req_write4, done4, busy4, sclk4, ncs4, copi4, cipo4;
    logic [6:0] req_addr4;
    logic [7:0] req_wdata4, rd_data4;

    int checks = 0;
    int errors = 0;

    spi_cfg_controller #(.CLK_DIV(D), .ADDR_W(7), .DATA_W(8)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .done(done), .rd_data(rd_data), .busy(busy), .sclk(sclk), .ncs(ncs),
        .copi(copi), .cipo(cipo)
    );

    spi_cfg_controller #(.CLK_DIV(4), .ADDR_W(7), .DATA_W(8)) u_dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid4), .req_ready(req_ready4),
        .req_write(req_write4), .req_addr(req_addr4), .req_wdata(req_wdata4),
        .done(done4), .rd_data(rd_data4), .busy(busy4), .sclk(sclk4), .ncs(ncs4),
        .copi(copi4), .cipo(cipo4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Expected {ncs, sclk, copi} k cycles after the accepting edge.
    function automatic logic [2:0] exp_spi(input int k, input logic [15:0] f);
        int m;
        logic s, c;
        if (k >= 33 * D) return 3'b100;
        s = (k >= D) && ((((k - D) / D) % 2) == 0);
        m = k / (2 * D);
        c = (m <= 15) ? f[15 - m] : 1'b0;
        return {1'b0, s, c};
    endfunction

    // Behavioural model, stepped at posedge and compared at negedge.
    logic [7:0]  cur_rsp = 8'h00;
    bit          m_valid = 1'b0;
    bit          m_busy  = 1'b0;
    bit          m_done  = 1'b0;
    int          m_k     = 0;
    logic [15:0] m_frame = 16'h0000;
    logic [7:0]  m_rsp   = 8'h00;
    logic [7:0]  m_rd    = 8'h00;

    initial begin
        logic [2:0] e;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_valid = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_k = 0; m_rd = 8'h00;
            end else begin
                m_done = 1'b0;
                if (m_busy) begin
                    m_k++;
                    if (m_k == 34 * D) begin
                        m_busy = 1'b0; m_done = 1'b1; m_rd = m_rsp;
                    end
                end else if (req_valid) begin
                    m_busy  = 1'b1;
                    m_k     = 0;
                    m_frame = {req_write, req_addr, (req_write ? req_wdata : 8'h00)};
                    m_rsp   = cur_rsp;
                end
            end
            @(negedge clk);
            if (m_valid) begin
                e = m_busy ? exp_spi(m_k, m_frame) : 3'b100;
                chk("ncs",     32'(ncs),       32'(e[2]));
                chk("sclk",    32'(sclk),      32'(e[1]));
                chk("copi",    32'(copi),      32'(e[0]));
                chk("done",    32'(done),      32'(m_done));
                chk("ready",   32'(req_ready), 32'(!m_busy));
                chk("busy",    32'(busy),      32'(m_busy));
                chk("rd_data", 32'(rd_data),   32'(m_rd));
            end
        end
    end

    // Peripheral stand-in: presents {0x00, cur_rsp} on CIPO, shifting on sclk falls.
    initial begin
        logic        p_ncs = 1'b1, p_sclk = 1'b0;
        logic [15:0] pfr = 16'h0000;
        int          pidx = 0;
        cipo  = 1'b0;
        cipo4 = 1'b0;
        forever begin
            @(negedge clk);
            if (p_ncs && !ncs) begin
                pfr = {8'h00, cur_rsp}; pidx = 0; cipo = pfr[15];
            end else if (p_sclk && !sclk && !ncs) begin
                pidx++;
                cipo = (pidx < 16) ? pfr[15 - pidx] : 1'b0;
            end
            p_ncs  = ncs;
            p_sclk = sclk;
        end
    end

    // Frame monitor: COPI at each sclk rise, ncs low/high run lengths, done timing.
    int          cyc = 0, fall_cyc = 0, rises = 0, ncs_low = 0, gap = 0, last_gap = 0;
    int          done_total = 0, done_off = 0, falls = 0;
    logic [15:0] cap = 16'h0000;

    initial begin
        logic n_prev = 1'b1, s_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!n_prev && ncs) gap = 0;
            if (ncs) gap++;
            if (n_prev && !ncs) begin
                fall_cyc = cyc; cap = 16'h0000; rises = 0; ncs_low = 0; last_gap = gap; falls++;
            end
            if (!ncs) ncs_low++;
            if (!s_prev && sclk) begin
                rises++; cap = {cap[14:0], copi};
            end
            if (done) begin
                done_total++; done_off = cyc - fall_cyc;
            end
            n_prev = ncs;
            s_prev = sclk;
        end
    end

    task automatic start(input logic w, input logic [6:0] a, input logic [7:0] d, input logic [7:0] rsp);
        @(negedge clk);
        req_write = w; req_addr = a; req_wdata = d; cur_rsp = rsp; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (done_total != d0) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        chk({nm, "_done_seen"}, 32'(ok), 32'd1);
    endtask

    task automatic check_frame(input string nm, input logic [15:0] f, input logic [7:0] rd);
        chk({nm, "_frame"},    32'(cap),      32'(f));
        chk({nm, "_rises"},    32'(rises),    32'd16);
        chk({nm, "_ncs_low"},  32'(ncs_low),  32'd66);
        chk({nm, "_done_off"}, 32'(done_off), 32'd68);
        chk({nm, "_rd_data"},  32'(rd_data),  32'(rd));
    endtask

    initial begin
        int d0, f0;
        bit got;
        int r4, last4, perbad, sbad;
        logic p4;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 7'h00; req_wdata = 8'h00;
        req_valid4 = 1'b0; req_write4 = 1'b0; req_addr4 = 7'h00; req_wdata4 = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ncs",   32'(ncs),       32'd1);
        chk("rst_sclk",  32'(sclk),      32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rd",    32'(rd_data),   32'h00);
        rst = 1'b0;

        // Write 0x00 <- 0xFF
        d0 = done_total;
        start(1'b1, 7'h00, 8'hFF, 8'h81);
        wait_done(d0, "w00");
        check_frame("w00", 16'h80FF, 8'h81);
        chk("w00_one_done", 32'(done_total - d0), 32'd1);

        // Read 0x04, peripheral returns 0xA5; wdata must not leak into the frame
        d0 = done_total;
        start(1'b0, 7'h04, 8'h5A, 8'hA5);
        wait_done(d0, "r04");
        check_frame("r04", 16'h0400, 8'hA5);
        repeat (10) @(negedge clk);
        chk("r04_hold", 32'(rd_data), 32'hA5);

        // Back-to-back writes with req_valid held high
        d0 = done_total;
        @(negedge clk);
        req_write = 1'b1; req_addr = 7'h02; req_wdata = 8'h3C; cur_rsp = 8'h11; req_valid = 1'b1;
        repeat (3) @(negedge clk);
        req_addr = 7'h03; req_wdata = 8'hC3; cur_rsp = 8'h22;
        wait_done(d0, "b2b_a");
        check_frame("b2b_a", 16'h823C, 8'h11);
        @(negedge clk);
        req_valid = 1'b0;
        wait_done(d0 + 1, "b2b_b");
        check_frame("b2b_b", 16'h83C3, 8'h22);
        chk("b2b_gap", 32'(last_gap), 32'(D + 1));

        // req_valid pulsed while busy is ignored
        d0 = done_total;
        start(1'b1, 7'h05, 8'h11, 8'h44);
        repeat (10) @(negedge clk);
        req_valid = 1'b1; req_addr = 7'h7F; req_wdata = 8'hEE;
        @(negedge clk);
        chk("busy_ready_lo", 32'(req_ready), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        wait_done(d0, "busy");
        check_frame("busy", 16'h8511, 8'h44);
        f0 = falls;
        repeat (80) @(negedge clk);
        chk("busy_single_done", 32'(done_total - d0), 32'd1);
        chk("busy_no_frame",    32'(falls - f0),      32'd0);

        // Reset after the 5th sclk rise
        d0 = done_total;
        start(1'b1, 7'h06, 8'h77, 8'h99);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (rises >= 5) begin
                got = 1'b1;
                break;
            end
        end
        #1;
        chk("mid_reached_5", 32'(got), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_ncs",   32'(ncs),       32'd1);
        chk("mid_sclk",  32'(sclk),      32'd0);
        chk("mid_copi",  32'(copi),      32'd0);
        chk("mid_ready", 32'(req_ready), 32'd1);
        chk("mid_rd",    32'(rd_data),   32'h00);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("mid_no_done", 32'(done_total - d0), 32'd0);
        start(1'b1, 7'h01, 8'h55, 8'h66);
        wait_done(d0, "post_rst");
        check_frame("post_rst", 16'h8155, 8'h66);

        // CLK_DIV=4 instance: sclk period, edge count, sclk low while deselected
        @(negedge clk);
        req_write4 = 1'b1; req_addr4 = 7'h00; req_wdata4 = 8'h0F; req_valid4 = 1'b1;
        @(negedge clk);
        req_valid4 = 1'b0;
        got = 1'b0; r4 = 0; last4 = 0; perbad = 0; sbad = 0; p4 = sclk4;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ncs4 && sclk4) sbad++;
            if (!p4 && sclk4) begin
                r4++;
                if (r4 > 1 && (i - last4) != 8) perbad++;
                last4 = i;
            end
            p4 = sclk4;
            if (done4) begin
                got = 1'b1;
                break;
            end
        end
        chk("d4_done_seen",   32'(got),    32'd1);
        chk("d4_rises",       32'(r4),     32'd16);
        chk("d4_period_bad",  32'(perbad), 32'd0);
        chk("d4_sclk_ncs_hi", 32'(sbad),   32'd0);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
